// File: rtl/trace_buffer_ctrl.sv
// Circular-buffer controller around a dual-port trace RAM: never-stalling write side with
// drop counting, and a read side that drains through a 2-entry queue onto a tlast-framed stream.
module trace_buffer_ctrl #(
  parameter int WORD_SIZE  = 64,
  parameter int ADDR_SIZE  = 8,
  parameter int BATCH_SIZE = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 flush,
  output logic                 ram_write_enable_1,
  output logic [ADDR_SIZE-1:0] ram_address_1,
  output logic [WORD_SIZE-1:0] ram_data_in_1,
  output logic                 ram_write_enable_2,
  output logic [ADDR_SIZE-1:0] ram_address_2,
  input  logic [WORD_SIZE-1:0] ram_output_2,
  output logic                 m_tvalid,
  output logic [WORD_SIZE-1:0] m_tdata,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic [ADDR_SIZE:0]   fill_count,
  output logic [31:0]          drop_count
);

  localparam int                 DEPTH      = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0]   FILL_FULL  = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0]   BATCH_LAST = (ADDR_SIZE+1)'(BATCH_SIZE - 1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE    = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE:0]   CNT_ONE    = (ADDR_SIZE+1)'(1);

  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic [ADDR_SIZE:0]   r_fill;
  logic [31:0]          r_drop;
  logic                 r_inflight;
  logic [ADDR_SIZE-1:0] r_inflight_addr;
  logic [WORD_SIZE-1:0] r_q_data [2];
  logic [ADDR_SIZE-1:0] r_q_addr [2];
  logic [1:0]           r_q_cnt;
  logic [ADDR_SIZE:0]   r_batch;
  logic                 r_flush_pend;
  logic [ADDR_SIZE-1:0] r_flush_addr;
  logic                 r_hold_vld;
  logic                 r_hold_last;

  logic                 w_full;
  logic                 w_wr;
  logic                 w_pop;
  logic                 w_rd;
  logic [ADDR_SIZE:0]   w_unread;
  logic [2:0]           w_occ_after;
  logic                 w_push_slot;
  logic                 w_tlast_raw;
  logic                 w_head_is_flush;
  logic [ADDR_SIZE-1:0] w_flush_tgt;
  logic                 w_flush_ok;

  // Stream handshake: a word transfers on every edge where m_tvalid && m_tready; while
  // m_tvalid is high and m_tready low, m_tdata and m_tlast do not change.
  assign w_full      = (r_fill == FILL_FULL);
  assign w_wr        = in_valid && !w_full && !rst;
  assign w_pop       = m_tvalid && m_tready;
  assign w_unread    = r_fill - (ADDR_SIZE+1)'(r_q_cnt) - (ADDR_SIZE+1)'(r_inflight);
  assign w_occ_after = {1'b0, r_q_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd        = (w_unread != '0) && (w_occ_after < 3'd2);
  // Slot index of (count - pop); the queue never receives a push while holding two words.
  assign w_push_slot = r_q_cnt[0] ^ w_pop;

  assign w_head_is_flush = r_flush_pend && (r_q_addr[0] == r_flush_addr);
  assign w_tlast_raw     = (r_batch == BATCH_LAST) || w_head_is_flush;
  assign w_flush_tgt     = w_wr ? r_wr_ptr : (r_wr_ptr - PTR_ONE);
  // A flush whose target is the word leaving this very cycle is too late to frame it.
  assign w_flush_ok      = flush && !rst && (w_wr || (r_fill != '0)) &&
                           !(w_pop && !w_wr && (r_q_addr[0] == w_flush_tgt));

  assign ram_write_enable_1 = w_wr;
  assign ram_address_1      = r_wr_ptr;
  assign ram_data_in_1      = in_data;
  assign ram_write_enable_2 = 1'b0;
  assign ram_address_2      = r_rd_ptr;
  assign m_tvalid           = (r_q_cnt != 2'd0);
  assign m_tdata            = r_q_data[0];
  assign m_tlast            = m_tvalid && (r_hold_vld ? r_hold_last : w_tlast_raw);
  assign fill_count         = r_fill;
  assign drop_count         = r_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_fill          <= '0;
      r_drop          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_q_cnt         <= 2'd0;
      r_batch         <= '0;
      r_flush_pend    <= 1'b0;
      r_flush_addr    <= '0;
      r_hold_vld      <= 1'b0;
      r_hold_last     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_q_data[i] <= '0;
        r_q_addr[i] <= '0;
      end
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;

      r_inflight <= w_rd;
      if (w_rd) begin
        r_rd_ptr        <= r_rd_ptr + PTR_ONE;
        r_inflight_addr <= r_rd_ptr;
      end

      if (w_wr && !w_pop)      r_fill <= r_fill + CNT_ONE;
      else if (!w_wr && w_pop) r_fill <= r_fill - CNT_ONE;

      if (in_valid && w_full && (r_drop != 32'hFFFF_FFFF)) r_drop <= r_drop + 32'd1;

      if (w_pop) begin
        r_q_data[0] <= r_q_data[1];
        r_q_addr[0] <= r_q_addr[1];
      end
      if (r_inflight) begin
        r_q_data[w_push_slot] <= ram_output_2;
        r_q_addr[w_push_slot] <= r_inflight_addr;
      end
      r_q_cnt <= r_q_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

      if (w_pop) r_batch <= m_tlast ? '0 : (r_batch + CNT_ONE);

      // A new flush supersedes any pending one; a pending flush retires with its word.
      if (w_flush_ok) begin
        r_flush_pend <= 1'b1;
        r_flush_addr <= w_flush_tgt;
      end else if (w_pop && (m_tlast || w_head_is_flush)) begin
        r_flush_pend <= 1'b0;
      end

      // Freeze tlast of a stalled head so a late flush cannot change it mid-handshake.
      r_hold_vld  <= m_tvalid && !m_tready;
      r_hold_last <= m_tlast;
    end
  end

endmodule

// File: tb/tb_trace_buffer_ctrl.sv
// Bench for trace_buffer_ctrl: a dual-port RAM model, a queue-based reference of the
// buffer contents and packet framing, and one task per scenario.
module tb_trace_buffer_ctrl;
  localparam int W     = 64;
  localparam int A     = 8;
  localparam int B     = 128;
  localparam int DEPTH = 256;

  logic         clk, rst, in_valid, flush, m_tready;
  logic [W-1:0] in_data, ram_data_in_1, ram_output_2, m_tdata;
  logic         ram_write_enable_1, ram_write_enable_2, m_tvalid, m_tlast;
  logic [A-1:0] ram_address_1, ram_address_2;
  logic [A:0]   fill_count;
  logic [31:0]  drop_count;
  logic [W-1:0] mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stored words in order, plus packet framing state.
  logic [W-1:0] exp_q[$];
  int           rd_seq, wr_seq, batch_m, pend_seq;
  bit           pend_v;
  int unsigned  drop_m;

  trace_buffer_ctrl #(.WORD_SIZE(W), .ADDR_SIZE(A), .BATCH_SIZE(B)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .ram_write_enable_1(ram_write_enable_1), .ram_address_1(ram_address_1),
    .ram_data_in_1(ram_data_in_1), .ram_write_enable_2(ram_write_enable_2),
    .ram_address_2(ram_address_2), .ram_output_2(ram_output_2),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .fill_count(fill_count), .drop_count(drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_write_enable_1) mem[ram_address_1] <= ram_data_in_1;
    ram_output_2 <= mem[ram_address_2];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    rd_seq = 0; wr_seq = 0; batch_m = 0; pend_seq = 0; pend_v = 0; drop_m = 0;
  endtask

  // Drive one cycle (called at posedge+1), sample the DUT mid-cycle, advance the model.
  task automatic do_cycle(input logic v, input logic [W-1:0] d, input logic f,
                          input logic rdy, input logic r,
                          output logic popped, output logic got_v, output logic [W-1:0] got_d,
                          output logic got_last, output logic exp_ok, output logic [W-1:0] exp_d,
                          output logic exp_last, output logic got_we, output logic exp_we);
    bit full_m;
    in_valid = v; in_data = d; flush = f; m_tready = rdy; rst = r;
    #1;
    got_v    = m_tvalid;
    popped   = m_tvalid && m_tready && !r;
    got_d    = m_tdata;
    got_last = m_tlast;
    got_we   = ram_write_enable_1;
    exp_ok   = 1'b1;
    exp_d    = '0;
    exp_last = 1'b0;
    full_m   = (exp_q.size() == DEPTH);
    exp_we   = v && !full_m && !r;
    if (r) begin
      model_reset();
    end else begin
      if (popped) begin
        if (exp_q.size() == 0) begin
          exp_ok = 1'b0;
        end else begin
          exp_d    = exp_q.pop_front();
          exp_last = (batch_m == B - 1) || (pend_v && pend_seq == rd_seq);
          rd_seq++;
          if (exp_last) begin
            batch_m = 0;
            pend_v  = 0;
          end else begin
            batch_m++;
          end
        end
      end
      if (f && exp_we) begin
        pend_v   = 1;
        pend_seq = wr_seq;
      end
      if (exp_we) begin
        exp_q.push_back(d);
        wr_seq++;
      end else if (v && drop_m != 32'hFFFF_FFFF) begin
        drop_m++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic p, gv, gl, eo, el, gw, ew;
    logic [W-1:0] gd, ed;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, rand_word(), 1'b1, 1'b1, 1'b1, p, gv, gd, gl, eo, ed, el, gw, ew);
      n_tests++;
      if (gw !== 1'b0) begin n_fail++; $display("FAIL reset_we1: got %b want 0", gw); end
    end
    n_tests++;
    if ({m_tvalid, m_tlast, ram_write_enable_2} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: tvalid/tlast/we2 got %b want 000", {m_tvalid, m_tlast, ram_write_enable_2});
    end
    n_tests++;
    if (m_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    n_tests++;
    if (fill_count !== '0 || drop_count !== '0) begin
      n_fail++; $display("FAIL reset_counts: fill %0d drop %0d want 0 0", fill_count, drop_count);
    end
    n_tests++;
    if (ram_address_1 !== '0 || ram_address_2 !== '0) begin
      n_fail++; $display("FAIL reset_addr: a1 %0d a2 %0d want 0 0", ram_address_1, ram_address_2);
    end
  endtask

  task automatic test_single_word();
    logic p, gv, gl, eo, el, gw, ew;
    logic [W-1:0] gd, ed;
    int first = -1;
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, p, gv, gd, gl, eo, ed, el, gw, ew);
    do_cycle(1'b1, 64'hA5, 1'b0, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
    n_tests++;
    if (gw !== 1'b1) begin n_fail++; $display("FAIL single_we1: got %b want 1", gw); end
    for (int k = 1; k <= 6; k++) begin
      do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
      if (k < 3) begin
        n_tests++;
        if (fill_count !== 9'd1) begin n_fail++; $display("FAIL single_fill1: cycle %0d got %0d want 1", k, fill_count); end
      end
      if (p) begin
        if (first < 0) first = k;
        n_tests++;
        if (gd !== 64'hA5 || gl !== 1'b0) begin
          n_fail++; $display("FAIL single_data: got %h last %b want a5 last 0", gd, gl);
        end
      end
    end
    n_tests++;
    if (first != 3) begin n_fail++; $display("FAIL single_latency: first pop cycle %0d want 3", first); end
    n_tests++;
    if (fill_count !== '0) begin n_fail++; $display("FAIL single_fill0: got %0d want 0", fill_count); end
  endtask

  task automatic test_burst_full();
    logic p, gv, gl, eo, el, gw, ew;
    logic [W-1:0] gd, ed;
    int nwe = 0, first = -1, npop = 0;
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, p, gv, gd, gl, eo, ed, el, gw, ew);
    for (int i = 0; i < 300; i++) begin
      do_cycle(1'b1, rand_word(), 1'b0, 1'b0, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
      if (gw === 1'b1) nwe++;
      n_tests++;
      if (gw !== ew) begin n_fail++; $display("FAIL burst_we1: word %0d got %b want %b", i, gw, ew); end
    end
    n_tests++;
    if (nwe != 256) begin n_fail++; $display("FAIL burst_nwrites: got %0d want 256", nwe); end
    n_tests++;
    if (fill_count !== 9'd256) begin n_fail++; $display("FAIL burst_fill: got %0d want 256", fill_count); end
    n_tests++;
    if (drop_count !== 32'd44 || drop_count !== drop_m) begin
      n_fail++; $display("FAIL burst_drop: got %0d want 44", drop_count);
    end
    for (int c = 0; c < 300; c++) begin
      do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
      if (p) begin
        if (first < 0) first = c;
        n_tests++;
        if (!eo || gd !== ed || gl !== el) begin
          n_fail++; $display("FAIL burst_pop: idx %0d got %h/%b want %h/%b", npop, gd, gl, ed, el);
        end
        n_tests++;
        if (c - first != npop) begin n_fail++; $display("FAIL burst_gap: idx %0d at cycle %0d want %0d", npop, c, first + npop); end
        n_tests++;
        if (gl !== ((npop == 127) || (npop == 255))) begin
          n_fail++; $display("FAIL burst_tlast: idx %0d got %b", npop, gl);
        end
        npop++;
      end
    end
    n_tests++;
    if (npop != 256 || fill_count !== '0) begin
      n_fail++; $display("FAIL burst_drain: pops %0d fill %0d want 256 0", npop, fill_count);
    end
  endtask

  task automatic test_random_stream();
    logic p, gv, gl, eo, el, gw, ew, rdy, v;
    logic [W-1:0] gd, ed, prev_d;
    logic prev_stall = 1'b0, prev_last = 1'b0;
    int sent = 0, recv = 0, cyc = 0;
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, p, gv, gd, gl, eo, ed, el, gw, ew);
    prev_d = '0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 8000) begin
      v   = (sent < 1000) && ($urandom_range(0, 99) < 40);
      rdy = $urandom_range(0, 1) == 1;
      do_cycle(v, rand_word(), 1'b0, rdy, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
      if (v) sent++;
      cyc++;
      if (prev_stall) begin
        n_tests++;
        if (gv !== 1'b1 || gd !== prev_d || gl !== prev_last) begin
          n_fail++; $display("FAIL rand_stable: got v%b %h/%b want v1 %h/%b", gv, gd, gl, prev_d, prev_last);
        end
      end
      prev_stall = gv && !rdy;
      prev_d = gd;
      prev_last = gl;
      if (p) begin
        recv++;
        n_tests++;
        if (!eo || gd !== ed || gl !== el) begin
          n_fail++; $display("FAIL rand_pop: idx %0d got %h/%b want %h/%b", recv - 1, gd, gl, ed, el);
        end
      end
    end
    n_tests++;
    if (recv != 1000 || drop_count !== '0 || fill_count !== '0) begin
      n_fail++; $display("FAIL rand_totals: recv %0d drop %0d fill %0d want 1000 0 0", recv, drop_count, fill_count);
    end
  endtask

  task automatic test_flush();
    logic p, gv, gl, eo, el, gw, ew;
    logic [W-1:0] gd, ed;
    int npop = 0, nlast = 0;
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, p, gv, gd, gl, eo, ed, el, gw, ew);
    for (int c = 0; c < 150; c++) begin
      do_cycle(c < 133, rand_word(), c == 4, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
      if (p) begin
        n_tests++;
        if (!eo || gd !== ed || gl !== el) begin
          n_fail++; $display("FAIL flush_pop: idx %0d got %h/%b want %h/%b", npop, gd, gl, ed, el);
        end
        n_tests++;
        if (gl !== ((npop == 4) || (npop == 132))) begin
          n_fail++; $display("FAIL flush_tlast: idx %0d got %b", npop, gl);
        end
        if (gl) nlast++;
        npop++;
      end
    end
    n_tests++;
    if (npop != 133 || nlast != 2) begin
      n_fail++; $display("FAIL flush_totals: pops %0d tlasts %0d want 133 2", npop, nlast);
    end
  endtask

  task automatic test_full_pop_wrap();
    logic p, gv, gl, eo, el, gw, ew;
    logic [W-1:0] gd, ed;
    int cyc = 0;
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, p, gv, gd, gl, eo, ed, el, gw, ew);
    for (int i = 0; i < 256; i++)
      do_cycle(1'b1, rand_word(), 1'b0, 1'b0, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
    do_cycle(1'b1, rand_word(), 1'b0, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
    n_tests++;
    if (gw !== 1'b0 || p !== 1'b1) begin n_fail++; $display("FAIL fullpop_we: we1 %b pop %b want 0 1", gw, p); end
    n_tests++;
    if (fill_count !== 9'd255 || drop_count !== 32'd1) begin
      n_fail++; $display("FAIL fullpop_counts: fill %0d drop %0d want 255 1", fill_count, drop_count);
    end
    for (int i = 0; i < 773; i++) begin
      do_cycle(1'b1, rand_word(), 1'b0, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
      n_tests++;
      if (!p || !eo || gd !== ed || gl !== el) begin
        n_fail++; $display("FAIL wrap_pop: step %0d pop %b got %h/%b want %h/%b", i, p, gd, gl, ed, el);
      end
    end
    while (exp_q.size() != 0 && cyc < 400) begin
      do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
      cyc++;
      if (p) begin
        n_tests++;
        if (!eo || gd !== ed || gl !== el) begin
          n_fail++; $display("FAIL wrap_drain: got %h/%b want %h/%b", gd, gl, ed, el);
        end
      end
    end
    n_tests++;
    if (fill_count !== '0 || ram_address_1 !== 8'd5 || ram_address_2 !== 8'd5 || drop_count !== 32'd1) begin
      n_fail++; $display("FAIL wrap_end: fill %0d a1 %0d a2 %0d drop %0d want 0 5 5 1",
                         fill_count, ram_address_1, ram_address_2, drop_count);
    end
  endtask

  task automatic test_reset_midflight();
    logic p, gv, gl, eo, el, gw, ew;
    logic [W-1:0] gd, ed;
    int first = -1;
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, p, gv, gd, gl, eo, ed, el, gw, ew);
    for (int i = 0; i < 10; i++)
      do_cycle(1'b1, rand_word(), 1'b0, 1'b0, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
    do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
    n_tests++;
    if (!p || !eo || gd !== ed) begin n_fail++; $display("FAIL mid_prepop: pop %b got %h want %h", p, gd, ed); end
    do_cycle(1'b1, rand_word(), 1'b0, 1'b0, 1'b1, p, gv, gd, gl, eo, ed, el, gw, ew);
    n_tests++;
    if (m_tvalid !== 1'b0 || fill_count !== '0 || drop_count !== '0) begin
      n_fail++; $display("FAIL mid_reset: tvalid %b fill %0d drop %0d want 0 0 0", m_tvalid, fill_count, drop_count);
    end
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
      n_tests++;
      if (gv !== 1'b0) begin n_fail++; $display("FAIL mid_stale: cycle %0d tvalid %b want 0", k, gv); end
    end
    do_cycle(1'b1, rand_word(), 1'b0, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
    for (int k = 1; k <= 5; k++) begin
      do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, p, gv, gd, gl, eo, ed, el, gw, ew);
      if (p) begin
        if (first < 0) first = k;
        n_tests++;
        if (!eo || gd !== ed || gl !== 1'b0) begin
          n_fail++; $display("FAIL mid_post_data: got %h/%b want %h/0", gd, gl, ed);
        end
      end
    end
    n_tests++;
    if (first != 3) begin n_fail++; $display("FAIL mid_post_latency: first pop cycle %0d want 3", first); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; m_tready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_word();
    test_burst_full();
    test_random_stream();
    test_flush();
    test_full_pop_wrap();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
